// File: rtl/obi_mem_scrubber.sv
// OBI manager that fills a contiguous SRAM word range with a seeded pattern,
// or reads the range back and counts words that differ from that pattern.
module obi_mem_scrubber #(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    input  logic [31:0]              num_words_i,
    input  logic [31:0]              seed_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              err_cnt_o,
    output logic                     first_err_valid_o,
    output logic [AddrWidth-1:0]     first_err_addr_o,
    output logic                     obi_req_o,
    input  logic                     obi_gnt_i,
    output logic [AddrWidth-1:0]     obi_addr_o,
    output logic                     obi_we_o,
    output logic [DataWidth/8-1:0]   obi_be_o,
    output logic [DataWidth-1:0]     obi_wdata_o,
    output logic [IdWidth-1:0]       obi_aid_o,
    input  logic                     obi_rvalid_i,
    input  logic [DataWidth-1:0]     obi_rdata_i,
    input  logic [IdWidth-1:0]       obi_rid_i,
    input  logic                     obi_err_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned RepCnt   = DataWidth / 32;
    localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);

    localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(BeWidth);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeWidth - 1);
    localparam logic [OutWidth-1:0]  MaxOut    = OutWidth'(MaxOutstanding);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    state_e                 state_q;
    logic                   mode_q;        // 1 = check
    logic [31:0]            num_words_q;
    logic [31:0]            seed_q;
    logic [31:0]            issue_idx_q;
    logic [31:0]            rsp_idx_q;
    logic [AddrWidth-1:0]   rsp_addr_q;
    logic [OutWidth-1:0]    outst_q;

    logic                   issue_fire;
    logic                   rsp_fire;
    logic                   rsp_err;
    logic                   issue_more;
    logic [31:0]            issue_idx_nxt;
    logic [OutWidth-1:0]    outst_nxt;
    logic [AddrWidth-1:0]   start_base;

    // Responses are in order, so the ID carries no information for us.
    logic unused_rid;
    assign unused_rid = ^obi_rid_i;

    // Pattern word for index i, replicated across the data bus.
    function automatic logic [DataWidth-1:0] pattern(input logic [31:0] seed,
                                                     input logic [31:0] idx);
        return {RepCnt{seed ^ idx}};
    endfunction

    // Handshake decode and next-cycle issue/outstanding bookkeeping.
    always_comb begin
        issue_fire    = obi_req_o & obi_gnt_i;
        rsp_fire      = obi_rvalid_i & (state_q != ST_IDLE) & (outst_q != '0);
        issue_idx_nxt = issue_idx_q + 32'(issue_fire);
        outst_nxt     = outst_q + OutWidth'(issue_fire) - OutWidth'(rsp_fire);
        issue_more    = (issue_idx_nxt < num_words_q) && (outst_nxt < MaxOut);
        rsp_err       = rsp_fire &
                        (obi_err_i | (mode_q & (obi_rdata_i != pattern(seed_q, rsp_idx_q))));
        start_base    = base_addr_i & AlignMask;
    end

    // Control FSM with registered OBI request and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= ST_IDLE;
            mode_q            <= 1'b0;
            num_words_q       <= '0;
            seed_q            <= '0;
            issue_idx_q       <= '0;
            rsp_idx_q         <= '0;
            rsp_addr_q        <= '0;
            outst_q           <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            err_cnt_o         <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
            obi_req_o         <= 1'b0;
            obi_addr_o        <= '0;
            obi_we_o          <= 1'b0;
            obi_be_o          <= '0;
            obi_wdata_o       <= '0;
            obi_aid_o         <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q            <= mode_i;
                        num_words_q       <= num_words_i;
                        seed_q            <= seed_i;
                        issue_idx_q       <= '0;
                        rsp_idx_q         <= '0;
                        rsp_addr_q        <= start_base;
                        outst_q           <= '0;
                        busy_o            <= 1'b1;
                        err_cnt_o         <= '0;
                        first_err_valid_o <= 1'b0;
                        first_err_addr_o  <= '0;
                        obi_addr_o        <= start_base;
                        obi_we_o          <= ~mode_i;
                        obi_be_o          <= '1;
                        obi_wdata_o       <= mode_i ? '0 : pattern(seed_i, 32'd0);
                        obi_aid_o         <= '0;
                        if (num_words_i == 32'd0) begin
                            state_q   <= ST_DRAIN;
                            obi_req_o <= 1'b0;
                        end else begin
                            state_q   <= ST_ISSUE;
                            obi_req_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    outst_q     <= outst_nxt;
                    issue_idx_q <= issue_idx_nxt;

                    // Advance the request payload only once the current beat is granted.
                    if (issue_fire) begin
                        obi_addr_o  <= obi_addr_o + WordBytes;
                        obi_aid_o   <= issue_idx_nxt[IdWidth-1:0];
                        obi_wdata_o <= mode_q ? '0 : pattern(seed_q, issue_idx_nxt);
                    end

                    if (rsp_fire) begin
                        rsp_idx_q  <= rsp_idx_q + 32'd1;
                        rsp_addr_q <= rsp_addr_q + WordBytes;
                        if (rsp_err) begin
                            if (err_cnt_o != '1) begin
                                err_cnt_o <= err_cnt_o + 32'd1;
                            end
                            if (!first_err_valid_o) begin
                                first_err_valid_o <= 1'b1;
                                first_err_addr_o  <= rsp_addr_q;
                            end
                        end
                    end

                    // A pending request can only lose its grant condition via a grant.
                    obi_req_o <= (state_q == ST_ISSUE) && issue_more;

                    if (issue_idx_nxt == num_words_q) begin
                        if (outst_nxt == '0) begin
                            state_q <= ST_IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
            endcase
        end
    end

    // A response while busy must correspond to a granted request.
    rvalid_has_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (obi_rvalid_i && state_q != ST_IDLE) |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_obi_mem_scrubber.sv
// Self-checking bench: OBI memory/responder model plus spec-level scoreboard.
module tb_obi_mem_scrubber;

    localparam int unsigned AW = 48;
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 2;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start, mode;
    logic [AW-1:0]  base_addr;
    logic [31:0]    num_words, seed;
    logic           busy, done;
    logic [31:0]    err_cnt;
    logic           fe_valid;
    logic [AW-1:0]  fe_addr;
    logic           req, gnt;
    logic [AW-1:0]  addr;
    logic           we;
    logic [BW-1:0]  be;
    logic [DW-1:0]  wdata;
    logic [IW-1:0]  aid;
    logic           rvalid;
    logic [DW-1:0]  rdata;
    logic [IW-1:0]  rid;
    logic           rerr;

    obi_mem_scrubber #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_i(start), .mode_i(mode), .base_addr_i(base_addr),
        .num_words_i(num_words), .seed_i(seed),
        .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt),
        .first_err_valid_o(fe_valid), .first_err_addr_o(fe_addr),
        .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(addr), .obi_we_o(we),
        .obi_be_o(be), .obi_wdata_o(wdata), .obi_aid_o(aid),
        .obi_rvalid_i(rvalid), .obi_rdata_i(rdata), .obi_rid_i(rid), .obi_err_i(rerr)
    );

    typedef struct {
        bit            mode;
        logic [AW-1:0] base;
        int            num;
        logic [31:0]   seed;
        int            gnt_pct;
        int            lat;
        int            corrupt;     // word index to corrupt before run, -1 none
        logic [31:0]   err_mask;    // responses that return obi_err
        int            restart_at;  // cycle offset of an ignored start pulse, 0 none
        int            exp_err;     // -1: rely on model only
        bit            exp_fv;
        logic [AW-1:0] exp_fa;
    } vec_t;

    typedef struct {
        longint        due;
        logic [DW-1:0] data;
        logic          err;
        logic [IW-1:0] id;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [logic [AW-1:0]];
    rsp_t          rspq[$];
    int            gnt_pct = 100;
    int            lat = 1;

    // Scoreboard model state
    bit            m_mode;
    logic [AW-1:0] m_base;
    int            m_num;
    logic [31:0]   m_seed;
    logic [31:0]   m_err_mask;
    int            n_fire, n_rsp, m_err, tb_out;
    bit            m_fv;
    logic [AW-1:0] m_fa;
    bit            done_seen, first_req_seen;
    longint        done_cyc, first_req_cyc, last_rv_cyc, st_cyc;
    bit            hold_pending;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic          hold_we;
    logic [IW-1:0] hold_aid;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] s, input int unsigned i);
        return {(DW/32){s ^ 32'(i)}};
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] b, input int unsigned i);
        return b + AW'(i) * AW'(BW);
    endfunction

    // Responder: grant randomly, return responses in order after the configured latency.
    always @(posedge clk) begin
        #1;
        gnt = ($urandom_range(99) < gnt_pct);
        if (!rst_n) begin
            rspq.delete();
            rvalid = 1'b0; rdata = '0; rerr = 1'b0; rid = '0;
        end else if (rspq.size() > 0 && rspq[0].due <= cyc) begin
            rvalid = 1'b1; rdata = rspq[0].data; rerr = rspq[0].err; rid = rspq[0].id;
            void'(rspq.pop_front());
        end else begin
            rvalid = 1'b0; rdata = '0; rerr = 1'b0; rid = '0;
        end
    end

    // Mid-cycle monitor: memory side effects plus per-beat protocol and data checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            tb_out = 0;
            hold_pending = 0;
        end else begin
            logic [DW-1:0] rd;
            logic [AW-1:0] ea;
            bit            e;
            if (hold_pending) begin
                chk("req_held", DW'(req), DW'(1));
                chk("addr_held", DW'(addr), DW'(hold_addr));
                chk("wdata_held", wdata, hold_wdata);
                chk("we_held", DW'(we), DW'(hold_we));
                chk("aid_held", DW'(aid), DW'(hold_aid));
            end
            if (req && !first_req_seen) begin
                first_req_seen = 1;
                first_req_cyc = cyc;
            end
            if (req && gnt) begin
                ea = word_addr(m_base, n_fire);
                chk("req_addr", DW'(addr), DW'(ea));
                chk("req_we", DW'(we), DW'(!m_mode));
                chk("req_be", DW'(be), DW'({BW{1'b1}}));
                chk("req_aid", DW'(aid), DW'(n_fire % 4));
                chk("req_wdata", wdata, m_mode ? '0 : pat(m_seed, n_fire));
                rd = mem.exists(addr) ? mem[addr] : '0;
                if (we) mem[addr] = wdata;
                rspq.push_back('{due: cyc + longint'(lat), data: we ? '0 : rd,
                                 err: (n_fire < 32) ? m_err_mask[n_fire] : 1'b0,
                                 id: aid});
                n_fire++;
                tb_out++;
            end
            hold_pending = req && !gnt;
            hold_addr = addr; hold_wdata = wdata; hold_we = we; hold_aid = aid;
            if (rvalid) begin
                e = ((n_rsp < 32) && m_err_mask[n_rsp]) || (m_mode && rdata != pat(m_seed, n_rsp));
                if (e) begin
                    m_err++;
                    if (!m_fv) begin
                        m_fv = 1;
                        m_fa = word_addr(m_base, n_rsp);
                    end
                end
                n_rsp++;
                tb_out--;
                last_rv_cyc = cyc;
            end
            if (req && gnt) chk("outstanding_le_2", DW'(tb_out <= 2), DW'(1));
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                chk("busy_low_at_done", DW'(busy), DW'(0));
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [AW-1:0] ca;
        gnt_pct = v.gnt_pct;
        lat = v.lat;
        m_base = v.base & ~AW'(BW - 1);
        if (v.corrupt >= 0) begin
            ca = word_addr(m_base, v.corrupt);
            if (mem.exists(ca)) mem[ca] = mem[ca] ^ DW'(1);
        end
        m_mode = v.mode; m_num = v.num; m_seed = v.seed; m_err_mask = v.err_mask;
        n_fire = 0; n_rsp = 0; m_err = 0; m_fv = 0; m_fa = '0;
        done_seen = 0; first_req_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; base_addr = v.base;
        num_words = 32'(v.num); seed = v.seed;
        st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); base_addr = AW'({$urandom(), $urandom()});
        num_words = $urandom; seed = $urandom;
        if (v.restart_at > 0) begin
            repeat (v.restart_at - 1) begin @(posedge clk); #1; end
            start = 1'b1; mode = ~v.mode; base_addr = '0; num_words = 32'd3;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_done_seen"}, DW'(done_seen), DW'(1));
        if (!done_seen) begin
            reset_dut();
            return;
        end
        if (v.num > 0) begin
            chk({tag, "_first_req_latency"}, DW'(first_req_cyc - st_cyc), DW'(1));
            chk({tag, "_done_after_last_rvalid"}, DW'(done_cyc - last_rv_cyc), DW'(1));
        end else begin
            chk({tag, "_done_latency_zero_words"}, DW'(done_cyc - st_cyc), DW'(2));
            chk({tag, "_no_req"}, DW'(first_req_seen), DW'(0));
        end
        chk({tag, "_grants"}, DW'(n_fire), DW'(v.num));
        chk({tag, "_responses"}, DW'(n_rsp), DW'(v.num));
        chk({tag, "_err_cnt"}, DW'(err_cnt), DW'(m_err));
        chk({tag, "_first_err_valid"}, DW'(fe_valid), DW'(m_fv));
        chk({tag, "_first_err_addr"}, DW'(fe_addr), DW'(m_fa));
        chk({tag, "_busy_idle"}, DW'(busy), DW'(0));
        if (v.exp_err >= 0) begin
            chk({tag, "_tbl_err_cnt"}, DW'(err_cnt), DW'(v.exp_err));
            chk({tag, "_tbl_first_err_valid"}, DW'(fe_valid), DW'(v.exp_fv));
            if (v.exp_fv) chk({tag, "_tbl_first_err_addr"}, DW'(fe_addr), DW'(v.exp_fa));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, DW'(req), DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_err_cnt"}, DW'(err_cnt), DW'(0));
        chk({tag, "_fe_valid"}, DW'(fe_valid), DW'(0));
        chk({tag, "_fe_addr"}, DW'(fe_addr), DW'(0));
        chk({tag, "_addr"}, DW'(addr), DW'(0));
        chk({tag, "_we"}, DW'(we), DW'(0));
        chk({tag, "_be"}, DW'(be), DW'(0));
        chk({tag, "_wdata"}, wdata, DW'(0));
        chk({tag, "_aid"}, DW'(aid), DW'(0));
    endtask

    vec_t tbl[11];

    initial begin
        logic [DW-1:0] exp_word;
        vec_t rv;
        tbl[0]  = '{1'b0, 48'h1000, 8, 32'hA5A5A5A5, 100, 1, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[1]  = '{1'b1, 48'h1000, 8, 32'hA5A5A5A5, 100, 1, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[2]  = '{1'b1, 48'h1000, 8, 32'hA5A5A5A5, 100, 1,  5, 32'h0, 0, 1, 1'b1, 48'h1140};
        tbl[3]  = '{1'b0, 48'h2000, 16, 32'h12345678, 50, 3, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[4]  = '{1'b1, 48'h2000, 16, 32'h12345678, 50, 3, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[5]  = '{1'b0, 48'h3000, 8, 32'h0, 100, 1, -1, 32'h14, 3, 2, 1'b1, 48'h3080};
        tbl[6]  = '{1'b0, 48'h3000, 0, 32'h1, 100, 1, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[7]  = '{1'b0, 48'h4027, 4, 32'hCAFEF00D, 70, 2, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[8]  = '{1'b1, 48'h4000, 4, 32'hCAFEF00D, 70, 2,  2, 32'h0, 0, 1, 1'b1, 48'h4080};
        tbl[9]  = '{1'b0, 48'hFFFF_FFFF_FFC0, 3, 32'h5, 100, 2, -1, 32'h0, 0, 0, 1'b0, 48'h0};
        tbl[10] = '{1'b1, 48'hFFFF_FFFF_FFC0, 3, 32'h5, 100, 2, -1, 32'h4, 0, 1, 1'b1, 48'h40};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0;
        num_words = '0; seed = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rerr = 1'b0;
        tb_out = 0; hold_pending = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
            if (i == 0) begin
                exp_word = {16{32'hA5A5A5A6}};
                chk("fill_word3_data", mem[48'h10C0], exp_word);
                exp_word = {16{32'hA5A5A5A5}};
                chk("fill_word0_data", mem[48'h1000], exp_word);
            end
        end

        for (int r = 0; r < 6; r++) begin
            rv.base = AW'({$urandom(), $urandom()});
            rv.num = $urandom_range(1, 20);
            rv.seed = $urandom;
            rv.gnt_pct = $urandom_range(30, 100);
            rv.lat = $urandom_range(1, 3);
            rv.restart_at = 0;
            rv.exp_err = -1; rv.exp_fv = 1'b0; rv.exp_fa = '0;
            rv.mode = 1'b0; rv.corrupt = -1;
            rv.err_mask = $urandom & $urandom & $urandom;
            run_vec(rv, $sformatf("rnd%0d_fill", r));
            rv.mode = 1'b1;
            rv.corrupt = ($urandom_range(1) == 1) ? int'($urandom_range(0, rv.num - 1)) : -1;
            rv.err_mask = $urandom & $urandom & $urandom;
            rv.gnt_pct = $urandom_range(30, 100);
            rv.lat = $urandom_range(1, 3);
            run_vec(rv, $sformatf("rnd%0d_check", r));
        end

        // Reset in the middle of a stalled fill run
        gnt_pct = 50; lat = 3;
        m_base = 48'h5000; m_mode = 1'b0; m_num = 16; m_seed = 32'h77; m_err_mask = 32'h1;
        n_fire = 0; n_rsp = 0; m_err = 0; m_fv = 0; m_fa = '0;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base_addr = 48'h5000; num_words = 32'd16; seed = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("midrun_busy_before_reset", DW'(busy), DW'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        run_vec(tbl[7], "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
